ps2_scancode_encoder: RTL and testbench
=======================================

PS2_SCANCODE_ENCODER -- requirements
Module: ps2_scancode_encoder

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 4, meaning idle cycles inserted after every emitted byte (legal range 1..255).
REQ-002 SHALL have port CLOCK_50  input  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  key request present.
REQ-005 SHALL have port req_key  input  4  key id: 0-9 digits, 10 Enter, 11 ESC, 12 Right arrow, 13-15 invalid.
REQ-006 SHALL have port req_ready  output  1  high only in IDLE; request accepted when req_valid && req_ready.
REQ-007 SHALL have port scancode  output  8  current PS/2 set-2 byte, held stable between pulses.
REQ-008 SHALL have port ps2_pressed  output  1  one-cycle strobe per emitted byte.
REQ-009 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-010 SHALL have port err_key  output  1  one-cycle pulse when an invalid key id is accepted.

Function
REQ-011 SHALL map digits 0-9 to make codes 45,16,1E,26,25,2E,36,3D,3E,46 (hex), Enter to 5A, ESC to 76, Right arrow to E0-prefixed 74.
REQ-012 SHALL implement FSM states IDLE, EMIT, GAP: IDLE->EMIT on accepted valid key; EMIT->GAP always after one cycle; GAP->EMIT when gap counter expires and bytes remain; GAP->IDLE when gap counter expires after the last byte.
REQ-013 SHALL, for a request accepted at cycle N, assert the first ps2_pressed at cycle N+1 and byte k (k from 0) at cycle N+1+k*(GAP_CYCLES+1).
REQ-014 SHALL hold ps2_pressed low for exactly GAP_CYCLES cycles after each pulse, including after the last byte.
REQ-015 SHALL update scancode in the same cycle as its ps2_pressed pulse and keep that value until the next pulse.
REQ-016 SHALL track the position in the byte sequence with a byte index counter of at least 3 bits (maximum sequence is 5 bytes).
REQ-017 SHALL ignore req_valid while req_ready is low; requests are neither queued nor merged.
REQ-018 SHALL, on an accepted invalid id (13-15), pulse err_key at N+1, emit no bytes, leave scancode unchanged, and keep req_ready high at N+1.
REQ-019 SHALL hold req_ready high at N+1 after an accepted invalid id, allowing a back-to-back request to be accepted in that cycle.

Reset
REQ-020 SHALL, when reset is sampled high, enter IDLE on the next edge with scancode=00, ps2_pressed=0, busy=0, err_key=0, req_ready=1, gap counter and byte index at 0.
REQ-021 SHALL, when reset is asserted mid-sequence, abort the sequence with no further ps2_pressed pulse; the remaining bytes SHALL NOT be resumed after reset.
REQ-022 SHALL give reset priority over a simultaneous req_valid; the request is dropped.

Configuration
REQ-023 SHALL honour macro PS2_ENC_BREAK_EN: when defined, each key emits make then break (digit: code,F0,code; Right: E0,74,E0,F0,74).
REQ-024 SHALL, when PS2_ENC_BREAK_EN is undefined, emit make codes only (digit: code; Right: E0,74), with all timing rules unchanged.

Verification (GAP_CYCLES=2)
REQ-025 SHALL verify: with break enabled, req_key=1 accepted at cycle 0 -> pulses at cycles 1,4,7 carrying 16,F0,16; busy low and req_ready high at cycle 10.
REQ-026 SHALL verify: with break enabled, req_key=12 accepted at cycle 0 -> pulses at 1,4,7,10,13 carrying E0,74,E0,F0,74; req_ready high at cycle 16.
REQ-027 SHALL verify: req_key=15 accepted at cycle 0 -> err_key pulse at cycle 1, no ps2_pressed, scancode unchanged, req_ready high at cycle 1.
REQ-028 SHALL verify: req_key=0 accepted at cycle 0 with reset high at cycle 5 -> only pulses at cycles 1 and 4; scancode=00 and req_ready=1 from cycle 6; no pulse afterward.
REQ-029 SHALL verify: with break disabled, req_key=10 accepted at cycle 0 -> single 5A pulse at cycle 1; req_ready high at cycle 4.
REQ-030 SHALL verify: req_valid held high continuously with req_key=3 -> second 26 sequence starts exactly one cycle after req_ready reasserts; no pulses overlap.

Source files
------------

// File: rtl/ps2_scancode_encoder.sv
// PS/2 set-2 scancode emitter: one key request in, one strobe per byte out, GAP_CYCLES idle cycles after each byte.
// First byte one cycle after accept; req_ready only in IDLE, no queuing. Define PS2_ENC_BREAK_EN to append break codes.
module ps2_scancode_encoder #(
    parameter int GAP_CYCLES = 4
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [3:0] req_key,
    output logic       req_ready,
    output logic [7:0] scancode,
    output logic       ps2_pressed,
    output logic       busy,
    output logic       err_key
);

    typedef enum logic [1:0] {IDLE, EMIT, GAP} state_t;

    localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);

    state_t     state;
    logic [7:0] gap_cnt;
    logic [2:0] byte_idx;
    logic [3:0] key;

    function automatic logic [7:0] make_code(input logic [3:0] k);
        case (k)
            4'd0:    make_code = 8'h45;
            4'd1:    make_code = 8'h16;
            4'd2:    make_code = 8'h1E;
            4'd3:    make_code = 8'h26;
            4'd4:    make_code = 8'h25;
            4'd5:    make_code = 8'h2E;
            4'd6:    make_code = 8'h36;
            4'd7:    make_code = 8'h3D;
            4'd8:    make_code = 8'h3E;
            4'd9:    make_code = 8'h46;
            4'd10:   make_code = 8'h5A;
            4'd11:   make_code = 8'h76;
            4'd12:   make_code = 8'h74;
            default: make_code = 8'h00;
        endcase
    endfunction

    function automatic logic [2:0] seq_len(input logic [3:0] k);
`ifdef PS2_ENC_BREAK_EN
        seq_len = (k == 4'd12) ? 3'd5 : 3'd3;
`else
        seq_len = (k == 4'd12) ? 3'd2 : 3'd1;
`endif
    endfunction

    // Right arrow is the only extended key; its bytes carry the E0 prefix.
    function automatic logic [7:0] seq_byte(input logic [3:0] k, input logic [2:0] idx);
        logic [7:0] mk;
        mk       = make_code(k);
        seq_byte = mk;
        if (k == 4'd12) begin
            case (idx)
                3'd0:    seq_byte = 8'hE0;
                3'd2:    seq_byte = 8'hE0;
                3'd3:    seq_byte = 8'hF0;
                default: seq_byte = mk;
            endcase
        end else if (idx == 3'd1) begin
            seq_byte = 8'hF0;
        end
    endfunction

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state       <= IDLE;
            scancode    <= 8'h00;
            ps2_pressed <= 1'b0;
            err_key     <= 1'b0;
            gap_cnt     <= 8'd0;
            byte_idx    <= 3'd0;
            key         <= 4'd0;
        end else begin
            ps2_pressed <= 1'b0;
            err_key     <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (req_key <= 4'd12) begin
                            key         <= req_key;
                            byte_idx    <= 3'd0;
                            scancode    <= seq_byte(req_key, 3'd0);
                            ps2_pressed <= 1'b1;
                            state       <= EMIT;
                        end else begin
                            err_key <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    gap_cnt  <= GAP_LOAD;
                    byte_idx <= byte_idx + 3'd1;
                    state    <= GAP;
                end
                GAP: begin
                    if (gap_cnt != 8'd0) begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end else if (byte_idx == seq_len(key)) begin
                        byte_idx <= 3'd0;
                        state    <= IDLE;
                    end else begin
                        scancode    <= seq_byte(key, byte_idx);
                        ps2_pressed <= 1'b1;
                        state       <= EMIT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_scancode_encoder.sv
// Directed bench for ps2_scancode_encoder with a timed scoreboard of expected bytes.
module tb_ps2_scancode_encoder;

    localparam int G = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic [3:0] req_key = 4'd0;
    logic       req_ready;
    logic [7:0] scancode;
    logic       ps2_pressed;
    logic       busy;
    logic       err_key;

    ps2_scancode_encoder #(.GAP_CYCLES(G)) dut (
        .CLOCK_50    (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_key     (req_key),
        .req_ready   (req_ready),
        .scancode    (scancode),
        .ps2_pressed (ps2_pressed),
        .busy        (busy),
        .err_key     (err_key)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] code;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;
    logic [7:0] last_code = 8'h00;
    logic [7:0] mk_tab [13] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
                                8'h3D, 8'h3E, 8'h46, 8'h5A, 8'h76, 8'h74};

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Every strobe must match the head of the scoreboard in both byte and cycle.
    always @(negedge clk) begin
        if (ps2_pressed === 1'b1) begin
            if (sb.size() == 0) begin
                check("stray_pulse", 32'(scancode), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pulse_byte", 32'(scancode), 32'(e.code));
                check("pulse_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Queue the expected bytes of a key accepted at cycle base; returns byte count.
    function automatic int push_seq(input int k, input int base);
        logic [7:0] b[$];
        logic [7:0] mk;
        mk = mk_tab[k];
        if (k == 12) b = '{8'hE0, mk};
        else         b = '{mk};
`ifdef PS2_ENC_BREAK_EN
        if (k == 12) begin b.push_back(8'hE0); b.push_back(8'hF0); b.push_back(mk); end
        else begin b.push_back(8'hF0); b.push_back(mk); end
`endif
        foreach (b[i]) begin
            exp_t e;
            e.code = b[i];
            e.cyc  = base + 1 + i * (G + 1);
            sb.push_back(e);
            last_code = b[i];
        end
        return b.size();
    endfunction

    // One-cycle request; leaves the bench #1 after the accepting edge.
    task automatic send(input int k, output int c);
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_key   = 4'(k);
        c = cyc;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int exp_cyc);
        int n;
        n = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle_cycle"}, 32'(cyc), 32'(exp_cyc));
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int c, r, len, len2;

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_scancode", 32'(scancode), 32'h00);
        check("rst_pressed", 32'(ps2_pressed), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err_key), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);

        // Every valid key once, checking bytes, spacing and return to IDLE.
        for (int k = 0; k <= 12; k++) begin
            @(posedge clk); #1;
            req_valid = 1'b1;
            req_key   = 4'(k);
            c   = cyc;
            len = push_seq(k, c);
            @(posedge clk); #1;
            req_valid = 1'b0;
            wait_idle($sformatf("key%0d", k), c + 1 + len * (G + 1));
        end

        // Invalid id: err pulse, no bytes, scancode untouched, still ready.
        send(15, c);
        @(negedge clk);
        check("inv_err", 32'(err_key), 32'd1);
        check("inv_ready", 32'(req_ready), 32'd1);
        check("inv_scancode", 32'(scancode), 32'(last_code));
        check("inv_cycle", 32'(cyc), 32'(c + 1));
        @(negedge clk);
        check("inv_err_clear", 32'(err_key), 32'd0);

        // Invalid id immediately followed by a valid one in the next cycle.
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_key   = 4'd14;
        @(posedge clk); #1;
        req_key = 4'd5;
        c   = cyc;
        len = push_seq(5, c);
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_idle("b2b", c + 1 + len * (G + 1));

        // Reset mid-sequence, with a simultaneous request that must be dropped.
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_key   = 4'd0;
        c = cyc;
        begin
            exp_t e;
            e.code = 8'h45; e.cyc = c + 1; sb.push_back(e);
`ifdef PS2_ENC_BREAK_EN
            e.code = 8'hF0; e.cyc = c + 4; sb.push_back(e);
`endif
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset     = 1'b1;
        req_valid = 1'b1;
        req_key   = 4'd2;
        @(posedge clk); #1;
        reset     = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        check("mrst_cycle", 32'(cyc), 32'(c + 6));
        check("mrst_scancode", 32'(scancode), 32'h00);
        check("mrst_ready", 32'(req_ready), 32'd1);
        check("mrst_busy", 32'(busy), 32'd0);
        repeat (20) @(negedge clk);
        check("mrst_sb_empty", 32'(sb.size()), 32'd0);

        // req_valid held high: second sequence accepted the cycle ready returns.
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_key   = 4'd3;
        c    = cyc;
        len  = push_seq(3, c);
        r    = c + 1 + len * (G + 1);
        len2 = push_seq(3, r);
        while (cyc < r + 1) @(posedge clk);
        #1 req_valid = 1'b0;
        wait_idle("hold", r + 1 + len2 * (G + 1));

        repeat (10) @(negedge clk);
        check("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
